// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan bus: digit positions,
// capture FSM states, segment patterns and small position helpers.
package seg_pkg;

  // Digit position in scan order; value equals the position index.
  typedef enum logic [1:0] {
    DIG_THOUSAND = 2'd0,
    DIG_HUNDRED  = 2'd1,
    DIG_TEN      = 2'd2,
    DIG_ONE      = 2'd3
  } digit_idx_t;

  // Dk means the k-th digit in scan order is expected next.
  // The encoding deliberately matches digit_idx_t so the expected position
  // can be derived from the state by a cast.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2,
    D3   = 2'd3
  } state_t;

  // Segment patterns, bit0 = a ... bit6 = g, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  // One-hot anode select for a digit position (thousand is the MSB).
  function automatic logic [3:0] digit_an(input digit_idx_t idx);
    return 4'b1000 >> idx;
  endfunction

  // Position of a one-hot anode select; callers check one-hotness first.
  function automatic digit_idx_t an_to_idx(input logic [3:0] a);
    case (a)
      4'b0100: return DIG_HUNDRED;
      4'b0010: return DIG_TEN;
      4'b0001: return DIG_ONE;
      default: return DIG_THOUSAND;
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment to BCD decode; unknown patterns (including
// blank) decode to DIGIT_INVALID.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd
);

  // Pattern lookup with invalid fallback.
  always_comb begin
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = DIGIT_INVALID;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for the four-digit multiplexed seven-segment bus. Samples
// {an,leds}, waits for SETTLE identical samples, walks the scan order and
// publishes a complete frame at once.
// Optional feature macro: SEG_CAPTURE_ERRCNT_EN (saturating error counter).
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] leds,
  output logic [3:0] thousand,
  output logic [3:0] hundred,
  output logic [3:0] ten,
  output logic [3:0] one,
  output logic       frame_valid,
  output logic       code_err,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  logic [3:0] smp_an_reg;
  logic [6:0] smp_leds_reg;
  logic [3:0] cnt_reg;
  logic       done_reg;
  logic       accept;
  logic [3:0] cur_bcd;
  logic [3:0] shadow_reg [3];

  state_t     state_reg, state_next;
  logic       store_en;
  digit_idx_t store_idx;
  logic       publish;
  logic       seq_err_next;
  logic       code_err_next;

  // A digit is taken once per anode change, when its sample has been stable
  // for SETTLE cycles; a blanked bus is never taken.
  assign accept = (cnt_reg == SETTLE_W) && !done_reg && (smp_an_reg != 4'b0000);

  seg7_to_bcd u_dec (
    .seg (smp_leds_reg),
    .bcd (cur_bcd)
  );

  // Input sample register, settle counter and accepted-once flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_an_reg   <= 4'b0000;
      smp_leds_reg <= SEG_BLANK;
      cnt_reg      <= 4'd0;
      done_reg     <= 1'b0;
    end else begin
      smp_an_reg   <= an;
      smp_leds_reg <= leds;
      if ({an, leds} != {smp_an_reg, smp_leds_reg}) begin
        cnt_reg <= 4'd1;
      end else if (cnt_reg != 4'hF) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (an != smp_an_reg) begin
        done_reg <= 1'b0;
      end else if (cnt_reg == SETTLE_W) begin
        done_reg <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Scan-order tracking: next state, shadow store and pulse requests.
  always_comb begin
    state_next   = state_reg;
    store_en     = 1'b0;
    store_idx    = an_to_idx(smp_an_reg);
    publish      = 1'b0;
    seq_err_next = 1'b0;
    if (accept) begin
      if (!$onehot(smp_an_reg)) begin
        seq_err_next = 1'b1;
        state_next   = HUNT;
      end else if (smp_an_reg == digit_an(digit_idx_t'(state_reg))) begin
        store_en = 1'b1;
        if (state_reg == D3) begin
          publish    = 1'b1;
          state_next = HUNT;
        end else begin
          state_next = state_t'(state_reg + 2'd1);
        end
      end else if (smp_an_reg == digit_an(DIG_THOUSAND)) begin
        // Only reachable mid-frame: restart with this thousand digit.
        seq_err_next = 1'b1;
        store_en     = 1'b1;
        state_next   = D1;
      end else if (state_reg != HUNT) begin
        seq_err_next = 1'b1;
        state_next   = HUNT;
      end
    end
  end

  assign code_err_next = publish &&
                         ((shadow_reg[0] == DIGIT_INVALID) ||
                          (shadow_reg[1] == DIGIT_INVALID) ||
                          (shadow_reg[2] == DIGIT_INVALID) ||
                          (cur_bcd == DIGIT_INVALID));

  // Shadow digits for thousand/hundred/ten; the one digit goes straight out.
  for (genvar gi = 0; gi < 3; gi++) begin : g_shadow
    // Hold the decoded digit for this position until the frame completes.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow_reg[gi] <= 4'h0;
      end else if (store_en && (store_idx == digit_idx_t'(gi))) begin
        shadow_reg[gi] <= cur_bcd;
      end
    end
  end

  // Published frame, status pulses and lock flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thousand    <= 4'h0;
      hundred     <= 4'h0;
      ten         <= 4'h0;
      one         <= 4'h0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= publish;
      code_err    <= code_err_next;
      seq_err     <= seq_err_next;
      if (publish) begin
        thousand <= shadow_reg[0];
        hundred  <= shadow_reg[1];
        ten      <= shadow_reg[2];
        one      <= cur_bcd;
        locked   <= 1'b1;
      end else if (seq_err_next) begin
        locked <= 1'b0;
      end
    end
  end

`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  // Saturating count of error pulses; a coincident pair counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_reg <= 8'd0;
    end else if ((seq_err_next || code_err_next) && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: two instances (SETTLE = 1 and 3) share the
// same stimulus; a behavioural model predicts every output each cycle and a
// few literal expectations pin the model.
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] an = 4'b0000;
  logic [6:0] leds = 7'b0000000;

  logic [1:0][3:0] o_th, o_hu, o_te, o_on;
  logic [1:0]      o_fv, o_ce, o_se, o_lk;
  logic [1:0][7:0] o_ec;

  always #5 clk = ~clk;

  seg_scan_capture #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .an(an), .leds(leds),
    .thousand(o_th[0]), .hundred(o_hu[0]), .ten(o_te[0]), .one(o_on[0]),
    .frame_valid(o_fv[0]), .code_err(o_ce[0]), .seq_err(o_se[0]),
    .locked(o_lk[0]), .err_cnt(o_ec[0])
  );

  seg_scan_capture #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .an(an), .leds(leds),
    .thousand(o_th[1]), .hundred(o_hu[1]), .ten(o_te[1]), .one(o_on[1]),
    .frame_valid(o_fv[1]), .code_err(o_ce[1]), .seq_err(o_se[1]),
    .locked(o_lk[1]), .err_cnt(o_ec[1])
  );

  logic [6:0] pats [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111};

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int          settle_m [2] = '{1, 3};
  logic [10:0] hist [2][16];   // registered samples, [0] most recent
  int          pos  [2];       // digits of the current frame collected so far
  int          fd   [2][4];    // frame under construction
  int          m_dig[2][4];
  int          m_fv [2], m_ce [2], m_se [2], m_lk [2], m_ec [2];

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return 15;
  endfunction

  function automatic int an_pos(input logic [3:0] a);
    case (a)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 16; k++) hist[m][k] = '0;
      for (int k = 0; k < 4; k++) begin fd[m][k] = 0; m_dig[m][k] = 0; end
      pos[m] = 0; m_fv[m] = 0; m_ce[m] = 0; m_se[m] = 0; m_lk[m] = 0; m_ec[m] = 0;
    end
  endtask

  task automatic model_digit(input int m, input logic [3:0] a, input int d);
    int p;
    p = an_pos(a);
    if (p < 0) begin
      m_se[m] = 1; pos[m] = 0;
    end else if (pos[m] == 0) begin
      if (p == 0) begin fd[m][0] = d; pos[m] = 1; end
    end else if (p == pos[m]) begin
      fd[m][p] = d;
      pos[m] = pos[m] + 1;
      if (pos[m] == 4) begin
        pos[m] = 0;
        m_fv[m] = 1;
        m_lk[m] = 1;
        for (int k = 0; k < 4; k++) begin
          m_dig[m][k] = fd[m][k];
          if (fd[m][k] == 15) m_ce[m] = 1;
        end
      end
    end else begin
      m_se[m] = 1;
      if (p == 0) begin fd[m][0] = d; pos[m] = 1; end
      else pos[m] = 0;
    end
    if (m_se[m] == 1) m_lk[m] = 0;
  endtask

  task automatic model_step(input int m);
    logic [10:0] cur;
    bit acc;
    int s;
    s = settle_m[m];
    cur = hist[m][0];
    m_fv[m] = 0; m_ce[m] = 0; m_se[m] = 0;
    // a sample is taken when it has just completed a run of exactly s samples
    acc = (cur[10:7] != 4'b0000) && (hist[m][s] != cur);
    for (int k = 1; k < s; k++) if (hist[m][k] != cur) acc = 0;
    if (acc) model_digit(m, cur[10:7], decode(cur[6:0]));
`ifdef SEG_CAPTURE_ERRCNT_EN
    if ((m_se[m] == 1 || m_ce[m] == 1) && m_ec[m] < 255) m_ec[m] = m_ec[m] + 1;
`endif
    for (int k = 15; k > 0; k--) hist[m][k] = hist[m][k-1];
    hist[m][0] = {an, leds};
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- checking ----------------
  int cyc = 0;
  int fv_cnt [2], ce_cnt [2], se_cnt [2];
  int last_fv = 0;
  int fv_gap = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    cyc++;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d thousand", m), int'(o_th[m]), m_dig[m][0]);
      chk($sformatf("u%0d hundred", m), int'(o_hu[m]), m_dig[m][1]);
      chk($sformatf("u%0d ten", m), int'(o_te[m]), m_dig[m][2]);
      chk($sformatf("u%0d one", m), int'(o_on[m]), m_dig[m][3]);
      chk($sformatf("u%0d frame_valid", m), int'(o_fv[m]), m_fv[m]);
      chk($sformatf("u%0d code_err", m), int'(o_ce[m]), m_ce[m]);
      chk($sformatf("u%0d seq_err", m), int'(o_se[m]), m_se[m]);
      chk($sformatf("u%0d locked", m), int'(o_lk[m]), m_lk[m]);
      chk($sformatf("u%0d err_cnt", m), int'(o_ec[m]), m_ec[m]);
      if (o_fv[m]) fv_cnt[m]++;
      if (o_ce[m]) ce_cnt[m]++;
      if (o_se[m]) se_cnt[m]++;
    end
    if (o_fv[0]) begin
      fv_gap = cyc - last_fv;
      last_fv = cyc;
    end
  endtask

  task automatic step_cycle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clr_counts();
    for (int m = 0; m < 2; m++) begin fv_cnt[m] = 0; ce_cnt[m] = 0; se_cnt[m] = 0; end
  endtask

  // Present one digit (d = 15 means blank segments) for n cycles.
  task automatic present(input logic [3:0] a, input int d, input int n);
    an = a;
    if (d < 10) leds = pats[d];
    else leds = 7'b0000000;
    for (int i = 0; i < n; i++) step_cycle();
    $display("present an=%b digit=%0d for %0d cycles", a, d, n);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input int n);
    present(4'b1000, d0, n);
    present(4'b0100, d1, n);
    present(4'b0010, d2, n);
    present(4'b0001, d3, n);
  endtask

  int exp_ec;

  initial begin
    clr_counts();
    // reset state
    for (int i = 0; i < 3; i++) step_cycle();
    chk("reset thousand", int'(o_th[0]), 0);
    chk("reset locked", int'(o_lk[1]), 0);
    chk("reset err_cnt", int'(o_ec[0]), 0);
    rst = 1'b1;
    present(4'b0000, 15, 2);

    // per-clock scan 1,2,3,4, three rounds
    clr_counts();
    for (int r = 0; r < 3; r++) scan(1, 2, 3, 4, 1);
    present(4'b0000, 15, 3);
    chk("scan1 u1 digits", int'({o_th[0], o_hu[0], o_te[0], o_on[0]}), 16'h1234);
    chk("scan1 u1 frames", fv_cnt[0], 3);
    chk("scan1 u1 frame period", fv_gap, 4);
    chk("scan1 u1 locked", int'(o_lk[0]), 1);
    chk("scan1 u1 code_err pulses", ce_cnt[0], 0);
    chk("scan1 u3 frames", fv_cnt[1], 0);

    // blank ten position
    clr_counts();
    scan(1, 2, 15, 4, 1);
    present(4'b0000, 15, 3);
    chk("blank u1 ten", int'(o_te[0]), 15);
    chk("blank u1 frames", fv_cnt[0], 1);
    chk("blank u1 code_err pulses", ce_cnt[0], 1);
`ifdef SEG_CAPTURE_ERRCNT_EN
    exp_ec = 1;
`else
    exp_ec = 0;
`endif
    chk("blank u1 err_cnt", int'(o_ec[0]), exp_ec);

    // out-of-order: thousand, hundred, one
    clr_counts();
    present(4'b1000, 9, 1);
    present(4'b0100, 9, 1);
    present(4'b0001, 9, 1);
    present(4'b0000, 15, 3);
    chk("order u1 seq_err pulses", se_cnt[0], 1);
    chk("order u1 locked", int'(o_lk[0]), 0);
    chk("order u1 digits kept", int'({o_th[0], o_hu[0], o_te[0], o_on[0]}), 16'h12F4);
`ifdef SEG_CAPTURE_ERRCNT_EN
    exp_ec = 2;
`else
    exp_ec = 0;
`endif
    chk("order u1 err_cnt", int'(o_ec[0]), exp_ec);

    // SETTLE = 3: hold 2 cycles never accepts, hold 3 completes
    clr_counts();
    scan(2, 4, 6, 8, 2);
    present(4'b0000, 15, 4);
    chk("hold2 u3 frames", fv_cnt[1], 0);
    chk("hold2 u3 thousand", int'(o_th[1]), 0);
    chk("hold2 u1 digits", int'({o_th[0], o_hu[0], o_te[0], o_on[0]}), 16'h2468);
    clr_counts();
    scan(2, 4, 6, 8, 3);
    present(4'b0000, 15, 4);
    chk("hold3 u3 frames", fv_cnt[1], 1);
    chk("hold3 u3 digits", int'({o_th[1], o_hu[1], o_te[1], o_on[1]}), 16'h2468);
    chk("hold3 u3 locked", int'(o_lk[1]), 1);

    // non-one-hot anode mid-frame, then a clean scan
    clr_counts();
    present(4'b1000, 1, 3);
    present(4'b0100, 2, 3);
    present(4'b0110, 0, 3);
    present(4'b0000, 15, 4);
    chk("0110 u1 seq_err pulses", se_cnt[0], 1);
    chk("0110 u3 seq_err pulses", se_cnt[1], 1);
    chk("0110 u3 locked", int'(o_lk[1]), 0);
    scan(5, 6, 7, 8, 3);
    present(4'b0000, 15, 4);
    chk("clean u1 digits", int'({o_th[0], o_hu[0], o_te[0], o_on[0]}), 16'h5678);
    chk("clean u3 digits", int'({o_th[1], o_hu[1], o_te[1], o_on[1]}), 16'h5678);

    // reset after the hundred digit is taken
    clr_counts();
    present(4'b1000, 3, 3);
    present(4'b0100, 3, 4);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst u1 digits", int'({o_th[0], o_hu[0], o_te[0], o_on[0]}), 0);
    chk("midrst u3 digits", int'({o_th[1], o_hu[1], o_te[1], o_on[1]}), 0);
    chk("midrst u3 locked", int'(o_lk[1]), 0);
    step_cycle();
    rst = 1'b1;
    present(4'b0010, 3, 3);
    present(4'b0001, 3, 3);
    present(4'b0000, 15, 4);
    chk("postrst partial frames", fv_cnt[0] + fv_cnt[1], 0);
    scan(9, 8, 7, 6, 3);
    present(4'b0000, 15, 4);
    chk("postrst u3 frames", fv_cnt[1], 1);
    chk("postrst u3 digits", int'({o_th[1], o_hu[1], o_te[1], o_on[1]}), 16'h9876);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
